layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 30 +++
 rtl/fixed_mul_q7_24.sv | 37 +++
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point types and FSM state encoding for the layer
// sequencer and its multiplier.
//   fixed_t     : signed Q7.24 value (1 sign, 7 integer, 24 fraction bits)
//   FRAC_BITS   : number of fraction bits in fixed_t
//   FIXED_MAX/MIN : saturation limits used when SEQ_SATURATE_EN is defined
//   seq_state_t : sequencer FSM states
//   idx_w()     : address width for an N-entry memory, never below one bit
package nn_pkg;

  localparam int unsigned FRAC_BITS = 24;

  typedef logic signed [31:0] fixed_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } seq_state_t;

  // $clog2(1) is 0; a single-entry memory still gets a 1-bit address.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_mul_q7_24.sv
// fixed_mul_q7_24: combinational signed Q7.24 x Q7.24 multiplier.
//   a, b : Q7.24 operands
//   p    : Q7.24 product = bits [55:24] of the 64-bit signed product
//          (truncation toward minus infinity, no rounding)
// Build option: SEQ_SATURATE_EN -- when defined, products outside the
// Q7.24 range clamp to FIXED_MAX / FIXED_MIN instead of wrapping.
module fixed_mul_q7_24
  import nn_pkg::*;
(
  input  fixed_t a,
  input  fixed_t b,
  output fixed_t p
);

  logic signed [63:0] full;

  assign full = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

`ifdef SEQ_SATURATE_EN
  logic signed [63:0] shifted;

  assign shifted = full >>> FRAC_BITS;

  // The shifted product fits in 32 bits only when its upper half is a pure
  // sign extension of bit 31.
  always_comb begin
    if (shifted == {{32{shifted[31]}}, shifted[31:0]}) begin
      p = fixed_t'(shifted);
    end else begin
      p = shifted[63] ? FIXED_MIN : FIXED_MAX;
    end
  end
`else
  assign p = fixed_t'(full >>> FRAC_BITS);
`endif

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: evaluates one fully connected neural-network layer with
// ReLU activation, time-sharing one Q7.24 multiplier across all neurons.
// Per neuron: LOAD (acc <= bias), PREV_LAYER_OUTPUTS MAC cycles, WRITE
// (one out_valid strobe); after the last neuron a one-cycle DONE.
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   start            : pulse requesting a layer evaluation (IDLE only)
//   busy             : high in LOAD, MAC and WRITE
//   done             : one-cycle pulse in the DONE state
//   in_addr/in_data  : input vector read port (combinational read)
//   w_addr/w_data    : weight read port, address n*PREV_LAYER_OUTPUTS+j
//   b_addr/b_data    : bias read port
//   out_valid/out_idx/out_data : ReLU result of neuron out_idx
// Build option: SEQ_SATURATE_EN -- saturate products and accumulation to
// the Q7.24 range; otherwise both wrap in 32-bit two's complement.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NEURONS            = 2,
  parameter int unsigned PREV_LAYER_OUTPUTS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic [idx_w(PREV_LAYER_OUTPUTS)-1:0]          in_addr,
  input  logic [31:0]                                   in_data,
  output logic [idx_w(NEURONS*PREV_LAYER_OUTPUTS)-1:0]  w_addr,
  input  logic [31:0]                                   w_data,
  output logic [idx_w(NEURONS)-1:0]                     b_addr,
  input  logic [31:0]                                   b_data,
  output logic                                          out_valid,
  output logic [idx_w(NEURONS)-1:0]                     out_idx,
  output logic [31:0]                                   out_data
);

  localparam int unsigned IW = idx_w(PREV_LAYER_OUTPUTS);
  localparam int unsigned WW = idx_w(NEURONS * PREV_LAYER_OUTPUTS);
  localparam int unsigned NW = idx_w(NEURONS);

  localparam logic [IW-1:0] J_LAST = IW'(PREV_LAYER_OUTPUTS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

  seq_state_t    state_q, state_d;
  fixed_t        acc_q, acc_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] j_q, j_d;
  logic [WW-1:0] w_ptr_q, w_ptr_d;

  fixed_t prod;
  fixed_t acc_sum;

  fixed_mul_q7_24 u_mul (
    .a (in_data),
    .b (w_data),
    .p (prod)
  );

`ifdef SEQ_SATURATE_EN
  logic [32:0] sum_wide;

  always_comb begin
    sum_wide = {acc_q[31], acc_q} + {prod[31], prod};
    if (sum_wide[32] != sum_wide[31]) begin
      acc_sum = sum_wide[32] ? FIXED_MIN : FIXED_MAX;
    end else begin
      acc_sum = sum_wide[31:0];
    end
  end
`else
  always_comb begin
    acc_sum = acc_q + prod;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      j_q     <= '0;
      w_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      j_q     <= j_d;
      w_ptr_q <= w_ptr_d;
    end
  end

  // Outputs are decoded from the registered state so that reset clears
  // them at once. w_addr = n*P+j is kept as a running pointer: MAC cycles
  // walk the weight memory contiguously across neurons, so it only needs
  // an increment per MAC cycle and a clear on start.
  // busy stays low in DONE so that it drops together with the done pulse.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    n_d       = n_q;
    j_d       = j_q;
    w_ptr_d   = w_ptr_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    in_addr   = '0;
    w_addr    = '0;
    b_addr    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = '0;
          w_ptr_d = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        busy    = 1'b1;
        b_addr  = n_q;
        acc_d   = b_data;
        j_d     = '0;
        state_d = MAC;
      end

      MAC: begin
        busy    = 1'b1;
        in_addr = j_q;
        w_addr  = w_ptr_q;
        acc_d   = acc_sum;
        w_ptr_d = w_ptr_q + 1'b1;
        j_d     = j_q + 1'b1;
        if (j_q == J_LAST) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_idx   = n_q;
        out_data  = acc_q[31] ? '0 : acc_q;
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = LOAD;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: self-checking bench for layer_sequencer.
// Instance A uses NEURONS=2, PREV_LAYER_OUTPUTS=3; instance B uses the
// minimum sizes NEURONS=1, PREV_LAYER_OUTPUTS=1. Expected values come from
// a table of hand-computed vectors and from a Q7.24 arithmetic model.
module tb_layer_sequencer;

  localparam int unsigned N = 2;
  localparam int unsigned P = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // ---------------- instance A (2 neurons x 3 inputs) ----------------
  logic        start_a = 1'b0;
  logic        busy_a, done_a, out_valid_a;
  logic [1:0]  in_addr_a;
  logic [2:0]  w_addr_a;
  logic [0:0]  b_addr_a, out_idx_a;
  logic [31:0] in_data_a, w_data_a, b_data_a, out_data_a;

  logic [31:0] xin  [4];
  logic [31:0] wmem [8];
  logic [31:0] bmem [2];

  always_comb begin
    in_data_a = xin[in_addr_a];
    w_data_a  = wmem[w_addr_a];
    b_data_a  = bmem[b_addr_a];
  end

  layer_sequencer #(.NEURONS(N), .PREV_LAYER_OUTPUTS(P)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .in_addr(in_addr_a), .in_data(in_data_a),
    .w_addr(w_addr_a), .w_data(w_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a),
    .out_valid(out_valid_a), .out_idx(out_idx_a), .out_data(out_data_a)
  );

  // ---------------- instance B (1 neuron x 1 input) ----------------
  logic        start_b = 1'b0;
  logic        busy_b, done_b, out_valid_b;
  logic [0:0]  in_addr_b, w_addr_b, b_addr_b, out_idx_b;
  logic [31:0] x_b, wt_b, bias_b, out_data_b;

  layer_sequencer #(.NEURONS(1), .PREV_LAYER_OUTPUTS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .in_addr(in_addr_b), .in_data(x_b),
    .w_addr(w_addr_b), .w_data(wt_b),
    .b_addr(b_addr_b), .b_data(bias_b),
    .out_valid(out_valid_b), .out_idx(out_idx_b), .out_data(out_data_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fit32(input longint v);
`ifdef SEQ_SATURATE_EN
    if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_neuron(input int n);
    logic [31:0] acc;
    logic [31:0] pr;
    longint      full;
    acc = bmem[n];
    for (int j = 0; j < int'(P); j++) begin
      full = longint'($signed(xin[j])) * longint'($signed(wmem[n*int'(P)+j]));
      pr   = fit32(full >>> 24);
      acc  = fit32(longint'($signed(acc)) + longint'($signed(pr)));
    end
    return acc[31] ? 32'h0 : acc;
  endfunction

  // ---------------- stimulus table ----------------
  typedef struct {
    string       name;
    logic [31:0] x [3];
    logic [31:0] w [6];
    logic [31:0] b [2];
    logic [31:0] y [2];
  } vec_t;

  vec_t tbl [5];

  task automatic load_vec(input int i);
    for (int j = 0; j < 3; j++) xin[j] = tbl[i].x[j];
    for (int j = 0; j < 6; j++) wmem[j] = tbl[i].w[j];
    for (int j = 0; j < 2; j++) bmem[j] = tbl[i].b[j];
  endtask

  // ---------------- layer run on instance A ----------------
  int          cap_valid, cap_done, cap_lat, cap_order_ok;
  logic [31:0] cap_data [2];

  // Pulses start, then watches ncyc cycles. inject_at=c raises start again
  // during cycle c+1 after the start-sample edge (0 = never).
  task automatic run_a(input int ncyc, input int inject_at);
    cap_valid = 0; cap_done = 0; cap_lat = -1; cap_order_ok = 1;
    cap_data[0] = 32'hDEAD_BEEF; cap_data[1] = 32'hDEAD_BEEF;
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (out_valid_a) begin
        if (int'(out_idx_a) != cap_valid) cap_order_ok = 0;
        cap_data[out_idx_a] = out_data_a;
        cap_valid++;
      end
      if (done_a) begin
        cap_done++;
        if (cap_lat < 0) cap_lat = c;
      end
      @(posedge clk); #1;
      start_a = (c == inject_at);
    end
    start_a = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [31:0] y0, input logic [31:0] y1);
    check({tag, "_out0"},  cap_data[0], y0);
    check({tag, "_out1"},  cap_data[1], y1);
    check({tag, "_lat"},   32'(cap_lat), 32'd11);
    check({tag, "_nvld"},  32'(cap_valid), 32'd2);
    check({tag, "_ndone"}, 32'(cap_done), 32'd1);
    check({tag, "_order"}, 32'(cap_order_ok), 32'd1);
  endtask

  // ---------------- layer run on instance B ----------------
  task automatic run_b(input string tag, input logic [31:0] y);
    int nv, nd, lat;
    logic [31:0] d;
    nv = 0; nd = 0; lat = -1; d = 32'hDEAD_BEEF;
    start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid_b) begin nv++; d = out_data_b; end
      if (done_b) begin nd++; if (lat < 0) lat = c; end
      @(posedge clk); #1;
    end
    check({tag, "_out"},   d, y);
    check({tag, "_lat"},   32'(lat), 32'd4);
    check({tag, "_nvld"},  32'(nv), 32'd1);
    check({tag, "_ndone"}, 32'(nd), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int inj_tab [6];
    int nv, nd;
    logic [31:0] e0, e1;

    inj_tab = '{1, 2, 3, 6, 7, 8};

    tbl[0].name = "basic";
    tbl[0].x = '{32'h0100_0000, 32'h0200_0000, 32'hFF00_0000};
    tbl[0].w = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000,
                 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    tbl[0].b = '{32'h0000_0000, 32'h0040_0000};
    tbl[0].y = '{32'h0100_0000, 32'h0000_0000};

    tbl[1].name = "ovf";
    tbl[1].x = '{32'h6400_0000, 32'h6400_0000, 32'h0000_0000};
    tbl[1].w = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[1].b = '{32'h0000_0000, 32'h0040_0000};
`ifdef SEQ_SATURATE_EN
    tbl[1].y = '{32'h7FFF_FFFF, 32'h0040_0000};
`else
    tbl[1].y = '{32'h0000_0000, 32'h0040_0000};
`endif

    tbl[2].name = "mixed";
    tbl[2].x = '{32'h0040_0000, 32'h0080_0000, 32'h00C0_0000};
    tbl[2].w = '{32'h0200_0000, 32'h0200_0000, 32'h0200_0000,
                 32'h0100_0000, 32'h0000_0000, 32'hFF00_0000};
    tbl[2].b = '{32'hFF00_0000, 32'h00C0_0000};
    tbl[2].y = '{32'h0200_0000, 32'h0040_0000};

    tbl[3].name = "trunc";
    tbl[3].x = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3].w = '{32'h0080_0000, 32'h0000_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0080_0000, 32'h0000_0000};
    tbl[3].b = '{32'h0000_0010, 32'h0000_0010};
    tbl[3].y = '{32'h0000_0010, 32'h0000_000F};

    tbl[4].name = "bias_ext";
    tbl[4].x = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
    tbl[4].w = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4].b = '{32'h7FFF_FFFF, 32'h8000_0000};
    tbl[4].y = '{32'h7FFF_FFFF, 32'h0000_0000};

    for (int j = 0; j < 4; j++) xin[j] = '0;
    for (int j = 0; j < 8; j++) wmem[j] = '0;
    bmem[0] = '0; bmem[1] = '0;
    x_b = '0; wt_b = '0; bias_b = '0;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy_a), 32'd0);
    check("rst_done",     32'(done_a), 32'd0);
    check("rst_valid",    32'(out_valid_a), 32'd0);
    check("rst_data",     out_data_a, 32'd0);
    check("rst_waddr",    32'(w_addr_a), 32'd0);
    check("rst_busy_b",   32'(busy_b), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      run_a(14, 0);
      check_run(tbl[i].name, tbl[i].y[0], tbl[i].y[1]);
    end

    // ---- start during MAC is ignored ----
    load_vec(0);
    run_a(14, 2);
    check_run("start_mac_n0", 32'h0100_0000, 32'h0);
    run_a(14, 7);
    check_run("start_mac_n1", 32'h0100_0000, 32'h0);

    // ---- reset during MAC of neuron 1 ----
    load_vec(0);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy",  32'(busy_a), 32'd1);
    check("pre_rst_waddr", 32'(w_addr_a), 32'd4);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(busy_a), 32'd0);
    check("midrst_done",   32'(done_a), 32'd0);
    check("midrst_valid",  32'(out_valid_a), 32'd0);
    check("midrst_idx",    32'(out_idx_a), 32'd0);
    check("midrst_data",   out_data_a, 32'd0);
    check("midrst_inaddr", 32'(in_addr_a), 32'd0);
    check("midrst_waddr",  32'(w_addr_a), 32'd0);
    check("midrst_baddr",  32'(b_addr_a), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    nv = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_a) nv++;
      if (done_a) nd++;
    end
    check("post_rst_nvld",  32'(nv), 32'd0);
    check("post_rst_ndone", 32'(nd), 32'd0);
    @(posedge clk); #1;
    run_a(14, 0);
    check_run("after_rst", 32'h0100_0000, 32'h0);

    // ---- back-to-back: start in DONE ignored, start in next IDLE taken ----
    load_vec(2);
    run_a(11, 10);
    check("b2b_first_lat",   32'(cap_lat), 32'd11);
    check("b2b_first_ndone", 32'(cap_done), 32'd1);
    check("b2b_first_nvld",  32'(cap_valid), 32'd2);
    run_a(14, 0);
    check_run("b2b_second", 32'h0200_0000, 32'h0040_0000);

    // ---- minimum sizes: 1 neuron, 1 input ----
    x_b = 32'h0080_0000; wt_b = 32'h0080_0000; bias_b = 32'hFFC0_0000;
    run_b("edge_zero", 32'h0);
    bias_b = 32'h0040_0000;
    run_b("edge_pos", 32'h0080_0000);

    // ---- randomized layers against the model ----
    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < 3; j++)
        xin[j] = (t < 10) ? ($urandom_range(0, 32'h0800_0000) - 32'h0400_0000) : $urandom;
      for (int j = 0; j < 6; j++)
        wmem[j] = (t < 10) ? ($urandom_range(0, 32'h0800_0000) - 32'h0400_0000) : $urandom;
      for (int j = 0; j < 2; j++)
        bmem[j] = (t < 10) ? ($urandom_range(0, 32'h0800_0000) - 32'h0400_0000) : $urandom;
      e0 = model_neuron(0);
      e1 = model_neuron(1);
      run_a(14, (t % 2 == 1) ? inj_tab[$urandom_range(0, 5)] : 0);
      check_run($sformatf("rand%0d", t), e0, e1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
